// File: rtl/dot_result_writer.sv
// Dot-product result sink: buffers adder-tree results in a small FIFO, writes them
// row-major into the result RAM and keeps a running checksum of everything written.
module dot_result_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset_l,
  input  logic                  start,
  input  logic                  sum_valid,
  input  logic [DATA_WIDTH-1:0] sum_data,
  output logic                  sum_ready,
  input  logic                  mem_busy,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(N * N);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int RC_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [RC_W-1:0] LAST_RC = RC_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      wr_q, wr_d;
  logic [RC_W-1:0]       row_q, row_d;
  logic [RC_W-1:0]       col_q, col_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [PTR_W:0]        wptr_q, wptr_d;
  logic [PTR_W:0]        rptr_q, rptr_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];

  logic                  full_s, empty_s, active_s, push_s, pop_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic [ADDR_WIDTH-1:0] addr_s;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_s   = (wptr_q == rptr_q);
  assign full_s    = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign active_s  = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign sum_ready = (state_q == S_RUN) && !full_s && (acc_q < TOTAL);
  assign push_s    = sum_valid && sum_ready;
  assign pop_s     = active_s && !empty_s && !mem_busy;
  assign head_s    = fifo_q[rptr_q[PTR_W-1:0]];
  assign addr_s    = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(N) + ADDR_WIDTH'(col_q);

  // FIFO storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_q[wptr_q[PTR_W-1:0]] <= sum_data;
    end
  end

  // Next-state and datapath update; push is evaluated before pop so DRAIN->DONE wins.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    row_d   = row_q;
    col_d   = col_q;
    sum_d   = sum_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          acc_d   = {CNT_W{1'b0}};
          wr_d    = {CNT_W{1'b0}};
          row_d   = {RC_W{1'b0}};
          col_d   = {RC_W{1'b0}};
          sum_d   = {DATA_WIDTH{1'b0}};
          wptr_d  = {(PTR_W+1){1'b0}};
          rptr_d  = {(PTR_W+1){1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      S_RUN, S_DRAIN: begin
        if (push_s) begin
          wptr_d  = wptr_q + (PTR_W+1)'(1);
          acc_d   = acc_q + CNT_W'(1);
          state_d = (acc_d == TOTAL) ? S_DRAIN : state_q;
        end else begin
          wptr_d = wptr_q;
        end
        if (pop_s) begin
          rptr_d  = rptr_q + (PTR_W+1)'(1);
          wr_d    = wr_q + CNT_W'(1);
          sum_d   = sum_q + head_s;
          wen_d   = 1'b1;
          addr_d  = addr_s;
          wdata_d = head_s;
          if (col_q == LAST_RC) begin
            col_d = {RC_W{1'b0}};
            row_d = (row_q == LAST_RC) ? {RC_W{1'b0}} : row_q + RC_W'(1);
          end else begin
            col_d = col_q + RC_W'(1);
          end
          state_d = (wr_d == TOTAL) ? S_DONE : state_d;
        end else begin
          wen_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= S_IDLE;
      acc_q   <= {CNT_W{1'b0}};
      wr_q    <= {CNT_W{1'b0}};
      row_q   <= {RC_W{1'b0}};
      col_q   <= {RC_W{1'b0}};
      sum_q   <= {DATA_WIDTH{1'b0}};
      wptr_q  <= {(PTR_W+1){1'b0}};
      rptr_q  <= {(PTR_W+1){1'b0}};
      wen_q   <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sum_q   <= sum_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_wr_en   = wen_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;
  assign checksum    = sum_q;
  assign busy        = active_s;
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_dot_result_writer.sv
// Bench for dot_result_writer: an N=4 instance driven through scoreboarded runs and
// an N=64 instance for the idle and full-size wrap-around cases.
module tb_dot_result_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_start, a_valid, a_ready, a_mbusy, a_wen, a_busy, a_done;
  logic [15:0] a_data, a_wdata, a_sum;
  logic [11:0] a_addr;
  logic        b_rst_n, b_start, b_valid, b_ready, b_mbusy, b_wen, b_busy, b_done;
  logic [15:0] b_data, b_wdata, b_sum;
  logic [11:0] b_addr;

  dot_result_writer #(.DATA_WIDTH(16), .N(4), .ADDR_WIDTH(12), .FIFO_DEPTH(4)) dut_a (
    .clock(clk), .reset_l(a_rst_n), .start(a_start), .sum_valid(a_valid),
    .sum_data(a_data), .sum_ready(a_ready), .mem_busy(a_mbusy), .mem_wr_en(a_wen),
    .mem_addr(a_addr), .mem_wr_data(a_wdata), .checksum(a_sum), .busy(a_busy),
    .done(a_done));

  dot_result_writer #(.DATA_WIDTH(16), .N(64), .ADDR_WIDTH(12), .FIFO_DEPTH(4)) dut_b (
    .clock(clk), .reset_l(b_rst_n), .start(b_start), .sum_valid(b_valid),
    .sum_data(b_data), .sum_ready(b_ready), .mem_busy(b_mbusy), .mem_wr_en(b_wen),
    .mem_addr(b_addr), .mem_wr_data(b_wdata), .checksum(b_sum), .busy(b_busy),
    .done(b_done));

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [15:0] first;
    logic [15:0] step;
    logic [15:0] exp_sum;
  } vec_t;

  exp_t a_q[$];
  int   a_idx = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write of the N=4 instance must match the oldest accepted result.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_wen === 1'b1) begin
      if (a_q.size() == 0) begin
        check("a_unexpected_write", 32'd1, 32'd0);
      end else begin
        e = a_q.pop_front();
        check("a_wr_addr", {20'd0, a_addr}, {20'd0, e.addr});
        check("a_wr_data", {16'd0, a_wdata}, {16'd0, e.data});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock of the N=4 instance: sample at negedge, record an accept, step past posedge.
  task automatic a_cycle(output bit acc, output bit wen);
    @(negedge clk);
    acc = a_valid && a_ready;
    wen = a_wen;
    if (acc) begin
      a_q.push_back({a_idx[11:0], a_data});
      a_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic a_start_run(input string tag);
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    a_idx   = 0;
    check({tag, "_start_done"}, {31'd0, a_done}, 32'd0);
    check({tag, "_start_busy"}, {31'd0, a_busy}, 32'd1);
    check({tag, "_start_sum"}, {16'd0, a_sum}, 32'd0);
  endtask

  task automatic a_feed(input int n, input logic [15:0] first, input logic [15:0] step,
                        input int pulse_at);
    int got = 0;
    int budget = 0;
    bit pulsed = 1'b0;
    bit acc, wen;
    a_data  = first;
    a_valid = 1'b1;
    while (got < n && budget < 1000) begin
      if (pulse_at >= 0 && got == pulse_at && !pulsed) begin
        a_start = 1'b1;
        pulsed  = 1'b1;
      end
      a_cycle(acc, wen);
      a_start = 1'b0;
      if (acc) begin
        got++;
        a_data = a_data + step;
      end
      budget++;
    end
    a_valid = 1'b0;
    check("a_feed_count", got, n);
  endtask

  task automatic a_wait_done(input string tag, input logic [15:0] exp_sum);
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_last_wr_with_done"}, {31'd0, a_wen}, 32'd1);
    check({tag, "_checksum"}, {16'd0, a_sum}, {16'd0, exp_sum});
    check({tag, "_busy_low"}, {31'd0, a_busy}, 32'd0);
    check({tag, "_ready_low"}, {31'd0, a_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_sb_empty"}, a_q.size(), 32'd0);
    check({tag, "_done_held"}, {30'd0, a_done, a_wen}, 32'd2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[3];
    bit   acc, wen;
    int   got, wcount, budget, rdy_cnt, wen_cnt, b_acc, b_wr, b_bad;
    logic [11:0] b_last;

    tbl[0] = '{first: 16'h0001, step: 16'h0001, exp_sum: 16'h0088};
    tbl[1] = '{first: 16'hFFFF, step: 16'h0000, exp_sum: 16'hFFF0};
    tbl[2] = '{first: 16'h1000, step: 16'h1000, exp_sum: 16'h8000};

    a_rst_n = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_data = 16'h0000; a_mbusy = 1'b0;
    b_rst_n = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_data = 16'h0000; b_mbusy = 1'b0;
    #1;
    check("a_reset_ctrl", {a_ready, a_wen, a_busy, a_done}, 32'd0);
    check("a_reset_data", {a_addr, a_wdata}, 32'd0);
    check("a_reset_sum", {16'd0, a_sum}, 32'd0);
    check("b_reset_ctrl", {b_ready, b_wen, b_busy, b_done, b_sum}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // N=64 idle with valid held and no start: nothing may be accepted or written.
    b_valid = 1'b1;
    b_data  = 16'h1234;
    rdy_cnt = 0;
    wen_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (b_ready) rdy_cnt++;
      if (b_wen) wen_cnt++;
    end
    b_valid = 1'b0;
    check("b_idle_ready", rdy_cnt, 32'd0);
    check("b_idle_wen", wen_cnt, 32'd0);
    check("b_idle_done_sum", {b_done, b_sum}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      a_start_run("tbl");
      a_feed(16, tbl[i].first, tbl[i].step, -1);
      check("tbl_ready_after_last", {31'd0, a_ready}, 32'd0);
      a_wait_done("tbl", tbl[i].exp_sum);
    end

    // First-result latency: accept on edge k, write visible in the cycle after edge k+1.
    a_start_run("lat");
    a_valid = 1'b1;
    a_data  = 16'h0001;
    a_cycle(acc, wen);
    check("lat_accept", {31'd0, acc}, 32'd1);
    a_valid = 1'b0;
    a_cycle(acc, wen);
    check("lat_not_early", {31'd0, wen}, 32'd0);
    a_cycle(acc, wen);
    check("lat_write", {31'd0, wen}, 32'd1);
    a_feed(15, 16'h0002, 16'h0001, -1);
    a_wait_done("lat", 16'h0088);

    // mem_busy stalls pops: the FIFO fills to 4 and then back-pressures.
    a_mbusy = 1'b1;
    a_start_run("stall");
    a_valid = 1'b1;
    a_data  = 16'h0001;
    got     = 0;
    wen_cnt = 0;
    repeat (10) begin
      a_cycle(acc, wen);
      if (acc) begin
        got++;
        a_data = a_data + 16'h0001;
      end
      if (wen) wen_cnt++;
    end
    check("stall_accepts", got, 32'd4);
    check("stall_ready", {31'd0, a_ready}, 32'd0);
    check("stall_no_writes", wen_cnt, 32'd0);
    a_mbusy = 1'b0;
    a_cycle(acc, wen);
    if (acc) begin got++; a_data = a_data + 16'h0001; end
    wen_cnt = 0;
    rdy_cnt = 0;
    repeat (4) begin
      a_cycle(acc, wen);
      if (acc) begin got++; rdy_cnt++; a_data = a_data + 16'h0001; end
      if (wen) wen_cnt++;
    end
    check("stall_release_writes", wen_cnt, 32'd4);
    check("stall_accept_resumes", {31'd0, (rdy_cnt > 0)}, 32'd1);
    a_feed(16 - got, a_data, 16'h0001, -1);
    a_wait_done("stall", 16'h0088);

    // Start mid-run is ignored; start in DONE restarts from address 0.
    a_start_run("mid");
    a_feed(16, 16'h0001, 16'h0001, 5);
    a_wait_done("mid", 16'h0088);
    a_start_run("redo");
    a_feed(16, 16'h0101, 16'h0001, -1);
    a_wait_done("redo", 16'h1088);

    // Asynchronous reset after 7 writes, then a clean full run.
    a_start_run("rst");
    a_valid = 1'b1;
    a_data  = 16'h0001;
    wcount  = 0;
    budget  = 0;
    while (wcount < 7 && budget < 100) begin
      a_cycle(acc, wen);
      if (acc) a_data = a_data + 16'h0001;
      if (wen) wcount++;
      budget++;
    end
    check("rst_writes_before", wcount, 32'd7);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {a_ready, a_wen, a_busy, a_done}, 32'd0);
    check("rst_async_data", {a_addr, a_wdata}, 32'd0);
    check("rst_async_sum", {16'd0, a_sum}, 32'd0);
    a_valid = 1'b0;
    a_q.delete();
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    a_start_run("after_rst");
    a_feed(16, tbl[0].first, tbl[0].step, -1);
    check("after_rst_ready", {31'd0, a_ready}, 32'd0);
    a_wait_done("after_rst", tbl[0].exp_sum);

    // N=64 full run of 0xFFFF: checksum wraps, last address is 0xFFF.
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    b_valid = 1'b1;
    b_data  = 16'hFFFF;
    b_acc   = 0;
    b_wr    = 0;
    b_bad   = 0;
    b_last  = 12'h000;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (b_valid && b_ready) b_acc++;
      if (b_wen) begin
        if (b_addr != b_wr[11:0] || b_wdata != 16'hFFFF) b_bad++;
        b_last = b_addr;
        b_wr++;
      end
      if (b_done) break;
      @(posedge clk);
      #1;
      if (b_acc == 4096) b_valid = 1'b0;
    end
    check("b_accepts", b_acc, 32'd4096);
    check("b_writes", b_wr, 32'd4096);
    check("b_write_order", b_bad, 32'd0);
    check("b_last_addr", {20'd0, b_last}, 32'h0000_0FFF);
    check("b_checksum", {16'd0, b_sum}, 32'h0000_F000);
    check("b_done", {30'd0, b_done, b_busy}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
